// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch front end with credit-limited fetch queue
// Optional static predecode redirect enabled by `define BTFN_PREDICT_EN.
module ifu_fetch #(
  parameter int              XLEN      = 32,
  parameter int              INSTR_LEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              FQ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag,
  output logic                 predicted_taken_from_ifu
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   pf_rd_q, pf_wr_q;

  logic [INSTR_LEN-1:0] q_data_q [FQ_DEPTH];
  logic [XLEN-1:0]      q_tag_q  [FQ_DEPTH];
  logic                 q_pred_q [FQ_DEPTH];
  logic [XLEN-1:0]      pf_mem_q [FQ_DEPTH];

  logic            accept, push, pop, rsp_keep, redirect_now;
  logic [XLEN-1:0] rsp_tag;
  logic [CW:0]     credit_sum;

  assign rsp_tag  = pf_mem_q[pf_rd_q];
  assign rsp_keep = imem_rsp_valid & (state_q == ST_RUN) & ~pipe_flush;

`ifdef BTFN_PREDICT_EN
  // Backward branches and JAL are assumed taken; target is computed from the response's own tag.
  logic [20:0]     j_imm;
  logic [12:0]     b_imm;
  logic            is_jal, is_bwd_br;
  logic [XLEN-1:0] redirect_target;
  assign j_imm = {imem_rsp_data[31], imem_rsp_data[19:12], imem_rsp_data[20], imem_rsp_data[30:21], 1'b0};
  assign b_imm = {imem_rsp_data[31], imem_rsp_data[7], imem_rsp_data[30:25], imem_rsp_data[11:8], 1'b0};
  assign is_jal    = (imem_rsp_data[6:0] == 7'b1101111);
  assign is_bwd_br = (imem_rsp_data[6:0] == 7'b1100011) & imem_rsp_data[31];
  assign redirect_now = rsp_keep & (is_jal | is_bwd_br);
  assign redirect_target = is_jal ? rsp_tag + {{(XLEN-21){j_imm[20]}}, j_imm}
                                  : rsp_tag + {{(XLEN-13){b_imm[12]}}, b_imm};
`else
  assign redirect_now = 1'b0;
`endif

  assign credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = ~rst & ~pipe_flush & ~redirect_now & (state_q == ST_RUN) &
                          (credit_sum < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = rsp_keep;
  assign pop            = instr_valid & ~pipe_stall & ~pipe_flush;

  assign instr_valid              = (count_q != '0);
  assign instr                    = instr_valid ? q_data_q[rd_ptr_q] : '0;
  assign instr_tag                = instr_valid ? q_tag_q[rd_ptr_q] : '0;
  assign predicted_taken_from_ifu = instr_valid & q_pred_q[rd_ptr_q];

  always_comb begin
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    rd_ptr_d      = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    if (pipe_flush) begin
      drop_d     = outstanding_d;
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
`ifdef BTFN_PREDICT_EN
    end else if (redirect_now) begin
      drop_d     = outstanding_d;
      fetch_pc_d = redirect_target;
`endif
    end else begin
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_VEC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pf_rd_q       <= '0;
      pf_wr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (accept) pf_wr_q <= pf_wr_q + PTR_ONE;
      if (imem_rsp_valid) pf_rd_q <= pf_rd_q + PTR_ONE;
    end
  end

  // Storage arrays need no reset: outputs are qualified by count and tags by outstanding.
  always_ff @(posedge clk) begin
    if (accept) pf_mem_q[pf_wr_q] <= fetch_pc_q;
    if (push) begin
      q_data_q[wr_ptr_q] <= imem_rsp_data;
      q_tag_q[wr_ptr_q]  <= rsp_tag;
      q_pred_q[wr_ptr_q] <= redirect_now;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
// Prediction scenario runs only when BTFN_PREDICT_EN is defined.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        pipe_stall = 1'b0;
  logic        pipe_flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_tag;
  logic        predicted_taken_from_ifu;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .redirect_pc(redirect_pc),
    .instr(instr), .instr_valid(instr_valid), .instr_tag(instr_tag),
    .predicted_taken_from_ifu(predicted_taken_from_ifu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_acc = 0;
  logic [31:0] br_addr = 32'hFFFF_FFFF;
  logic [31:0] br_data = 32'hFE00_0EE3;
  logic [31:0] rsp_addr = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == br_addr) ? br_data : (32'hA000_0000 | a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the in-order imem model: accepted request answers lat cycles later.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    cyc++;
    if (acc) begin
      pend.push_back('{a, cyc + lat - 1});
      n_acc++;
    end
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      rsp_addr       = pend[0].addr;
      imem_rsp_data  = mem(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pipe_flush = 1'b0;
    pipe_stall = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_acc = 0;
    #1;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_tag", instr_tag, 0);
    chk("rst_pred", predicted_taken_from_ifu, 0);

    // sequential fetch, 1-cycle latency
    do_reset();
    lat = 1;
    chk("s1_req_valid", imem_req_valid, 1);
    chk("s1_addr0", imem_req_addr, 32'h0);
    tick();
    chk("s1_addr4", imem_req_addr, 32'h4);
    chk("s1_not_yet_valid", instr_valid, 0);
    tick();
    chk("s1_first_valid", instr_valid, 1);
    chk("s1_tag0", instr_tag, 32'h0);
    chk("s1_instr0", instr, 32'hA000_0000);
    chk("s1_addr8", imem_req_addr, 32'h8);
    tick();
    chk("s1_tag4", instr_tag, 32'h4);
    tick();
    chk("s1_tag8", instr_tag, 32'h8);
    tick();
    chk("s1_tagC", instr_tag, 32'hC);
    chk("s1_instrC", instr, 32'hA000_000C);
    // asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    chk("arst_instr_valid", instr_valid, 0);
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_addr", imem_req_addr, 32'h0);

    // stall: credit caps fetches at FQ_DEPTH
    do_reset();
    pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("s2_credit_stop", imem_req_valid, 0);
    chk("s2_addr_hold", imem_req_addr, 32'h10);
    for (int i = 0; i < 4; i++) tick();
    chk("s2_n_acc", n_acc, 4);
    chk("s2_req_still_off", imem_req_valid, 0);
    chk("s2_head_valid", instr_valid, 1);
    chk("s2_head_tag0", instr_tag, 32'h0);
    pipe_stall = 1'b0;
    #1;
    chk("s2_head_tag0_release", instr_tag, 32'h0);
    tick();
    chk("s2_pop_tag4", instr_tag, 32'h4);
    chk("s2_req_resume", imem_req_valid, 1);
    chk("s2_req_addr10", imem_req_addr, 32'h10);
    tick();
    chk("s2_pop_tag8", instr_tag, 32'h8);
    tick();
    chk("s2_pop_tagC", instr_tag, 32'hC);
    tick();
    chk("s2_pop_tag10", instr_tag, 32'h10);

    // flush with three requests in flight
    do_reset();
    lat = 3;
    tick(); tick(); tick();
    chk("s3_rsp_present", imem_rsp_valid, 1);
    pipe_flush  = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("s3_no_req_in_flush", imem_req_valid, 0);
    tick();
    pipe_flush = 1'b0;
    #1;
    chk("s3_queue_empty", instr_valid, 0);
    chk("s3_drain_a", imem_req_valid, 0);
    tick();
    chk("s3_drain_b", imem_req_valid, 0);
    chk("s3_drop_no_push", instr_valid, 0);
    tick();
    chk("s3_resume_valid", imem_req_valid, 1);
    chk("s3_resume_addr", imem_req_addr, 32'h100);
    chk("s3_still_empty", instr_valid, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("s3_new_head_valid", instr_valid, 1);
    chk("s3_new_head_tag", instr_tag, 32'h100);

    // imem not ready: request held
    do_reset();
    lat = 1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s4_hold_valid", imem_req_valid, 1);
      chk("s4_hold_addr", imem_req_addr, 32'h0);
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    tick();
    chk("s4_advance", imem_req_addr, 32'h4);

    // backward branch at 0x10
    do_reset();
    lat = 2;
    br_addr = 32'h10;
    n = 0;
    while (!(instr_valid && instr_tag == 32'h10) && n < 20) begin
      tick();
      n++;
    end
    chk("s5_reach_branch", n < 20, 1);
    chk("s5_branch_instr", instr, 32'hFE00_0EE3);
`ifdef BTFN_PREDICT_EN
    chk("s5_pred_taken", predicted_taken_from_ifu, 1);
    chk("s5_drain_no_req", imem_req_valid, 0);
    tick();
    chk("s5_younger_dropped", instr_valid, 0);
    chk("s5_redir_valid", imem_req_valid, 1);
    chk("s5_redir_addr", imem_req_addr, 32'hC);
`else
    chk("s5_pred_off", predicted_taken_from_ifu, 0);
    chk("s5_seq_valid", imem_req_valid, 1);
    chk("s5_seq_addr", imem_req_addr, 32'h1C);
    tick();
    chk("s5_next_tag", instr_tag, 32'h14);
`endif

    // flush in the same cycle as the branch response
    do_reset();
    lat = 2;
    n = 0;
    while (!(imem_rsp_valid && rsp_addr == 32'h10) && n < 20) begin
      tick();
      n++;
    end
    chk("s6_reach_branch_rsp", n < 20, 1);
    pipe_flush  = 1'b1;
    redirect_pc = 32'h200;
    #1;
    tick();
    pipe_flush = 1'b0;
    #1;
    chk("s6_no_entry", instr_valid, 0);
    chk("s6_drain", imem_req_valid, 0);
    tick();
    chk("s6_resume_valid", imem_req_valid, 1);
    chk("s6_resume_addr", imem_req_addr, 32'h200);
    chk("s6_still_empty", instr_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch front end. It generates sequential fetch PCs and issues requests to instruction memory. In-order responses are buffered in a small fetch queue, which drives the decode-stage input interface (instr/instr_valid/instr_tag/predicted_taken_from_ifu). It honours the pipeline pipe_stall/pipe_flush controls and applies an optional static branch prediction redirect.

Parameters:
XLEN, 32, address/tag width
INSTR_LEN, 32, instruction width
RESET_VEC, 32'h0000_0000, first fetch PC after reset
FQ_DEPTH, 4, fetch queue entries (power of 2, >=2); also the max in-flight requests plus queued entries

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  XLEN  fetch PC, word aligned
imem_rsp_valid  in  1  response valid; in order, no backpressure
imem_rsp_data  in  INSTR_LEN  fetched instruction
pipe_stall  in  1  decode not accepting; hold head
pipe_flush  in  1  redirect; kill queue and in-flight requests
redirect_pc  in  XLEN  new fetch PC, sampled when pipe_flush=1
instr  out  INSTR_LEN  queue head instruction
instr_valid  out  1  queue non-empty
instr_tag  out  XLEN  PC of head instruction
predicted_taken_from_ifu  out  1  head was predicted taken

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: fetch_pc=RESET_VEC; queue empty; outstanding=0; drop=0; imem_req_valid=0; instr_valid=0; instr=0; instr_tag=0; predicted_taken_from_ifu=0.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset release are not dropped; the imem must also be reset.
- Credit: imem_req_valid = ~pipe_flush & ~redirect_now & (count + outstanding < FQ_DEPTH) & (drop==0).
- Request handshake: accepted when imem_req_valid & imem_req_ready. On accept: fetch_pc += 4; outstanding += 1. imem_req_addr is held stable while valid and not ready.
- Response handling: if drop!=0, drop -= 1 and outstanding -= 1, data discarded. Otherwise push {data, tag = PC of the oldest in-flight request, pred}; outstanding -= 1. A per-request PC FIFO of depth FQ_DEPTH holds the tags.
- Output: head is driven combinationally from the queue. A response pushed in cycle N is visible at the output in cycle N+1 (no bypass).
- Pop: instr_valid & ~pipe_stall. Pop and push in the same cycle are legal at any occupancy, including full and empty.
- Pointers: wrap modulo FQ_DEPTH. count is 0..FQ_DEPTH, and is never exceeded because of credit.
- Flush (highest priority):
  - Next cycle: queue empty; instr_valid=0; fetch_pc=redirect_pc.
  - drop = outstanding after this cycle's accept/response accounting. Any response in the flush cycle is discarded.
  - No request is issued in the flush cycle. A pop in the flush cycle is ignored.
- Stall and flush together: flush wins.
- State machine:
  - RUN (normal).
  - DRAIN (drop!=0; no requests; responses discarded). Enters RUN when drop reaches 0.
  - Flush from any state recomputes drop.
  - Requests resume in the same cycle drop reaches 0.

Optional Feature:
BTFN_PREDICT_EN
- Defined: each non-dropped response is predecoded.
  - JAL (opcode 1101111) is predicted taken, target PC+J-imm.
  - B-type (opcode 1100011) with imm[12]=1 is predicted taken, target PC+B-imm.
  - On a taken response: the entry is pushed with pred=1; fetch_pc <= target; drop = outstanding-1 (younger requests killed); redirect_now suppresses a request that cycle.
  - pipe_flush in the same cycle overrides the prediction.
- Undefined: pred=0 always; no predecode redirect.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle response latency -> requests at 0x0,0x4,0x8,0xC; instr_valid first high 2 cycles after the first accept; tags 0x0,0x4,... in order.
- pipe_stall held high with FQ_DEPTH=4 -> exactly 4 requests outstanding or queued, then imem_req_valid=0; head stays tag 0x0 until stall drops; then 1 pop per cycle.
- 3 requests in flight, pipe_flush=1 with redirect_pc=0x100 -> next cycle instr_valid=0; 3 responses discarded; next request at 0x100 only after drop=0.
- imem_req_ready=0 for 5 cycles -> imem_req_valid=1 with addr 0x0 stable all 5 cycles; fetch_pc not advanced.
- BTFN_PREDICT_EN defined: response 0xFE000EE3 (bne? backward branch, imm=-4) at tag 0x10 -> entry pred=1; next request addr 0x0C; younger in-flight response dropped.
- Same as the previous scenario but pipe_flush with redirect_pc=0x200 in the same cycle -> next request 0x200, pred entry not queued.
